// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: cpustate decode values,
// arbiter FSM encoding, access-owner encoding and wait counter width.
package mem_pkg;

    localparam logic [1:0] CPUSTATE_IDLE  = 2'b00;
    localparam logic [1:0] CPUSTATE_IN    = 2'b01;
    localparam logic [1:0] CPUSTATE_CHECK = 2'b10;
    localparam logic [1:0] CPUSTATE_RUN   = 2'b11;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_PNL = 1'b1
    } owner_t;

    function automatic logic cpu_eligible(input logic [1:0] cs);
        return cs == CPUSTATE_RUN;
    endfunction

    function automatic logic pnl_eligible(input logic [1:0] cs);
        return (cs == CPUSTATE_IN) || (cs == CPUSTATE_CHECK);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester (CPU, front panel) and memory signals around mem_arbiter.
// master: requesters + memory side; slave: the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [1:0]    cpustate;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          pnl_req;
    logic          pnl_we;
    logic [AW-1:0] pnl_addr;
    logic [DW-1:0] pnl_wdata;
    logic          pnl_ack;
    logic [DW-1:0] pnl_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  cpustate, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  pnl_req, pnl_we, pnl_addr, pnl_wdata, mem_rdata,
        output cpu_ack, cpu_err, cpu_rdata, pnl_ack, pnl_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write, busy
    );

    modport master (
        output cpustate, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output pnl_req, pnl_we, pnl_addr, pnl_wdata, mem_rdata,
        input  cpu_ack, cpu_err, cpu_rdata, pnl_ack, pnl_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_wait_cnt.sv
// Wait-state counter: loads WAIT_CYCLES, counts down to zero, flags zero.
module mem_wait_cnt
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    logic [WAIT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU (RUN) and front-panel loader (IN/CHECK).
// Optional WRITE_PROTECT_EN: CPU writes at or below ROM_TOP are refused with cpu_err.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int ROM_TOP     = 31
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    arb_state_t    r_state;
    arb_state_t    w_state_next;
    owner_t        r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_pnl_rdata;

    logic w_cpu_elig;
    logic w_pnl_elig;
    logic w_grant;
    logic w_protect;
    logic w_cnt_zero;

    // Eligibility is only looked at in IDLE; an access in flight ignores cpustate.
    assign w_cpu_elig = cpu_eligible(bus.cpustate) && bus.cpu_req;
    assign w_pnl_elig = pnl_eligible(bus.cpustate) && bus.pnl_req;
    assign w_grant    = w_cpu_elig || w_pnl_elig;

    mem_wait_cnt #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_load(r_state == ST_IDLE),
        .i_dec (r_state == ST_ACCESS),
        .o_zero(w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = w_protect ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWNER_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == ST_IDLE) && w_grant) begin
            r_owner <= w_cpu_elig ? OWNER_CPU : OWNER_PNL;
            r_we    <= w_cpu_elig ? bus.cpu_we    : bus.pnl_we;
            r_addr  <= w_cpu_elig ? bus.cpu_addr  : bus.pnl_addr;
            r_wdata <= w_cpu_elig ? bus.cpu_wdata : bus.pnl_wdata;
        end
    end

    // Read data is sampled on the last strobe cycle and held until the owner's next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_pnl_rdata <= '0;
        end else if ((r_state == ST_ACCESS) && w_cnt_zero && !r_we) begin
            if (r_owner == OWNER_CPU) begin
                r_cpu_rdata <= bus.mem_rdata;
            end else begin
                r_pnl_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef WRITE_PROTECT_EN
    logic r_err;

    assign w_protect = w_cpu_elig && bus.cpu_we && (bus.cpu_addr <= AW'(ROM_TOP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_grant) begin
            r_err <= w_protect;
        end
    end

    assign bus.cpu_err = (r_state == ST_DONE) && (r_owner == OWNER_CPU) && r_err;
`else
    assign w_protect   = 1'b0;
    assign bus.cpu_err = 1'b0;
`endif

    // Strobes and acks decode straight from state so an async reset drops them at once.
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_read  = (r_state == ST_ACCESS) && !r_we;
    assign bus.mem_write = (r_state == ST_ACCESS) && r_we;
    assign bus.cpu_ack   = (r_state == ST_DONE) && (r_owner == OWNER_CPU);
    assign bus.pnl_ack   = (r_state == ST_DONE) && (r_owner == OWNER_PNL);
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.pnl_rdata = r_pnl_rdata;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// accesses against a simple memory/latency model. Honours WRITE_PROTECT_EN.
module tb_mem_arbiter;
    localparam int W = 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    mem_arbiter_if #(.AW(16), .DW(8)) bus ();

    mem_arbiter #(
        .AW(16), .DW(8), .WAIT_CYCLES(W), .ROM_TOP(31)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access by the eligible requester, compared against the model:
    // ack W+2 edges after request (1 for a refused write), strobe W+1 cycles.
    task automatic do_access(input logic who, input logic we, input logic [15:0] addr,
                             input logic [7:0] wd, input logic [1:0] cs_mid, input string tag);
        int         edges;
        int         strobes;
        int         bad;
        int         other_ack;
        logic       got;
        logic       err_seen;
        logic       prot;
        int         exp_lat;
        int         exp_str;
        logic [7:0] exp_rd;
        logic [7:0] old_val;
        logic [7:0] rd;
        prot = 1'b0;
`ifdef WRITE_PROTECT_EN
        prot = (who == 1'b0) && we && (addr <= 16'd31);
`endif
        exp_lat = prot ? 1 : W + 2;
        exp_str = prot ? 0 : W + 1;
        exp_rd  = ref_mem[addr[7:0]];
        old_val = ref_mem[addr[7:0]];
        if (who == 1'b0) begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
        end else begin
            bus.pnl_we = we; bus.pnl_addr = addr; bus.pnl_wdata = wd; bus.pnl_req = 1'b1;
        end
        edges = 0; strobes = 0; bad = 0; other_ack = 0; got = 1'b0; err_seen = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk);
            #1;
            edges = k;
            if (k == 1) bus.cpustate = cs_mid;
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                if (bus.mem_addr !== addr || bus.mem_write !== we || (we && bus.mem_wdata !== wd)) bad++;
            end
            if ((who == 1'b0) ? bus.pnl_ack : bus.cpu_ack) other_ack++;
            got = (who == 1'b0) ? bus.cpu_ack : bus.pnl_ack;
            if (got) err_seen = bus.cpu_err;
        end
        rd = (who == 1'b0) ? bus.cpu_rdata : bus.pnl_rdata;
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_strobes"}, strobes, exp_str);
        check({tag, "_busfields"}, bad, 0);
        check({tag, "_otherack"}, other_ack, 0);
        check({tag, "_err"}, {31'd0, err_seen}, {31'd0, prot});
        if (!we) begin
            check({tag, "_rdata"}, {24'd0, rd}, {24'd0, exp_rd});
        end else begin
            if (!prot) ref_mem[addr[7:0]] = wd;
            check({tag, "_memwr"}, {24'd0, mem[addr[7:0]]}, {24'd0, prot ? old_val : wd});
        end
        if (who == 1'b0) bus.cpu_req = 1'b0; else bus.pnl_req = 1'b0;
        tick();
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        $display("txn %s who=%0d we=%0d addr=%h wdata=%h rdata=%h lat=%0d", tag, who, we, addr, wd, rd, edges);
    endtask

    initial begin
        int         e1;
        int         e2;
        int         busy_seen;
        logic [7:0] v;
        logic [1:0] cs;
        logic       who;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[5] <= 8'hA7;
        ref_mem[5] = 8'hA7;
        bus.cpustate = 2'b00;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.pnl_req = 1'b0; bus.pnl_we = 1'b0; bus.pnl_addr = '0; bus.pnl_wdata = '0;
        reset = 1'b1;
        repeat (2) tick();
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 0);
        check("rst_acks", {29'd0, bus.cpu_ack, bus.pnl_ack, bus.cpu_err}, 0);
        check("rst_addr", {16'd0, bus.mem_addr}, 0);
        check("rst_wdata", {24'd0, bus.mem_wdata}, 0);
        check("rst_rdata", {16'd0, bus.cpu_rdata, bus.pnl_rdata}, 0);
        reset = 1'b0;
        tick();

        // cpustate 00: nobody is granted
        bus.cpu_req = 1'b1; bus.pnl_req = 1'b1;
        busy_seen = 0;
        repeat (6) begin
            tick();
            if (bus.busy || bus.cpu_ack || bus.pnl_ack) busy_seen++;
        end
        check("idle_no_grant", busy_seen, 0);
        bus.cpu_req = 1'b0; bus.pnl_req = 1'b0;

        bus.cpustate = 2'b11;
        do_access(1'b0, 1'b0, 16'h0005, 8'h00, 2'b11, "t1_cpu_rd");
        check("t1_value", {24'd0, bus.cpu_rdata}, 32'hA7);

        // Panel write in IN while an ineligible CPU request is pending
        bus.cpustate = 2'b01;
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0007; bus.cpu_wdata = 8'hEE; bus.cpu_req = 1'b1;
        do_access(1'b1, 1'b1, 16'h0003, 8'h3C, 2'b01, "t2_pnl_wr");
        bus.cpu_req = 1'b0;
        check("t2_cpu_untouched", {24'd0, mem[7]}, {24'd0, ref_mem[7]});

        // Held CPU request: back-to-back accesses
        bus.cpustate = 2'b11;
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 8'h55; bus.cpu_req = 1'b1;
        e1 = 0; e2 = 0;
        for (int k = 1; k <= 30 && e2 == 0; k++) begin
            tick();
            if (bus.cpu_ack) begin
                if (e1 == 0) e1 = k; else e2 = k;
            end
        end
        bus.cpu_req = 1'b0;
        ref_mem[8'h40] = 8'h55;
        tick();
        check("t3_first_ack", e1, W + 2);
        check("t3_ack_spacing", e2 - e1, W + 3);
        check("t3_mem", {24'd0, mem[8'h40]}, 32'h55);
        $display("txn t3_b2b first=%0d second=%0d", e1, e2);

        do_access(1'b0, 1'b1, 16'h001F, 8'h99, 2'b11, "t4_rom_top");
        do_access(1'b0, 1'b1, 16'h0020, 8'h66, 2'b11, "t4_above_rom");

        // Reset in the middle of an access
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0005; bus.cpu_req = 1'b1;
        tick();
        check("t5_in_access", {31'd0, bus.mem_read}, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_strobe", {30'd0, bus.mem_read, bus.mem_write}, 0);
        check("t5_rst_busy", {31'd0, bus.busy}, 0);
        check("t5_rst_rdata", {24'd0, bus.cpu_rdata}, 0);
        busy_seen = 0;
        repeat (3) begin
            tick();
            if (bus.cpu_ack) busy_seen++;
        end
        check("t5_no_ack", busy_seen, 0);
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        $display("txn t5_reset_mid_access");

        do_access(1'b0, 1'b0, 16'hAB09, 8'h00, 2'b01, "t5_cs_change");
        do_access(1'b1, 1'b0, 16'h0003, 8'h00, 2'b10, "t5_pnl_check");

        // Randomized accesses; the ineligible requester may also be asserted
        for (int n = 0; n < 24; n++) begin
            cs = 2'($urandom_range(1, 3));
            bus.cpustate = cs;
            who = (cs == 2'b11) ? 1'b0 : 1'b1;
            if (who == 1'b0) begin
                bus.pnl_we = 1'($urandom); bus.pnl_addr = 16'($urandom);
                bus.pnl_wdata = 8'($urandom); bus.pnl_req = 1'($urandom);
            end else begin
                bus.cpu_we = 1'($urandom); bus.cpu_addr = 16'($urandom);
                bus.cpu_wdata = 8'($urandom); bus.cpu_req = 1'($urandom);
            end
            do_access(who, 1'($urandom), 16'($urandom), 8'($urandom), cs, $sformatf("rnd%0d", n));
            bus.cpu_req = 1'b0;
            bus.pnl_req = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
